// File: rtl/alu_ab_datapath_if.sv
// Bus between the control sequencer / neighbouring CPU blocks and the A/B/ALU datapath.
interface alu_ab_datapath_if #(parameter int W = 4);
   logic [3:0]   opcode;
   logic [W-1:0] ram_in;
   logic [W-1:0] tmp_in;
   logic         carry_in;
   logic         la_ram, la_b, la_alu;
   logic         lb_tmp, lb_alu, lpop, lcarry, ercl;
   logic         eu;
   logic         ea_tmp, ea_ram, ea_out, ea_carry, eb_push;
   logic [W-1:0] a_to_tmp, a_to_ram, a_to_out, b_to_ram;
   logic         carry_from_a, carry_from_b;
   logic         zero, carry;
   logic [W-1:0] alu_result;

   modport master (
      output opcode, ram_in, tmp_in, carry_in,
      output la_ram, la_b, la_alu, lb_tmp, lb_alu, lpop, lcarry, ercl, eu,
      output ea_tmp, ea_ram, ea_out, ea_carry, eb_push,
      input  a_to_tmp, a_to_ram, a_to_out, b_to_ram,
      input  carry_from_a, carry_from_b, zero, carry, alu_result
   );

   modport slave (
      input  opcode, ram_in, tmp_in, carry_in,
      input  la_ram, la_b, la_alu, lb_tmp, lb_alu, lpop, lcarry, ercl, eu,
      input  ea_tmp, ea_ram, ea_out, ea_carry, eb_push,
      output a_to_tmp, a_to_ram, a_to_out, b_to_ram,
      output carry_from_a, carry_from_b, zero, carry, alu_result
   );
endinterface

// File: rtl/alu_ab_datapath.sv
// 4-bit CPU accumulator datapath: A and B registers plus a registered ALU with zero/carry flags.
// Optional macro ALU_CMP_EN enables opcode 0110 (CMP: flags as SUB, result held).
module alu_ab_datapath #(
   parameter int W = 4
) (
   input  logic              clk,
   input  logic              reset,
   alu_ab_datapath_if.slave  bus
);

   logic [W-1:0] a_reg, b_reg;
   logic [W-1:0] res_p1;
   logic         zero_p1, carry_p1, cfb_reg;
   logic [W+2:0] alu_w;

   // Packs {update_flags, update_result, carry, result}; operands are pre-edge register values.
   function automatic logic [W+2:0] alu_eval(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic [W-1:0] t);
      logic [W:0] r;
      logic       upd_res, upd_flg;
      r       = '0;
      upd_res = 1'b1;
      upd_flg = 1'b1;
      case (op)
         4'b0001: r = {1'b0, a} + {1'b0, b};
         4'b0010: r = {1'b0, a} - {1'b0, b};
         4'b0100: r = {1'b0, a} + {1'b0, t};
         4'b0101: r = {1'b0, a} - {1'b0, t};
         4'b1000: r = {1'b0, a & b};
         4'b1001: r = {1'b0, a | b};
         4'b1010: r = {1'b0, a ^ b};
         4'b1011: r = {1'b0, ~a};
         4'b1100: r = {1'b0, a} + (W+1)'(1);
         4'b1101: r = {1'b0, a} - (W+1)'(1);
`ifdef ALU_CMP_EN
         4'b0110: begin
            r       = {1'b0, a} - {1'b0, b};
            upd_res = 1'b0;
         end
`else
`endif
         default: begin
            upd_res = 1'b0;
            upd_flg = 1'b0;
         end
      endcase
      // Bit W of a zero-extended add/subtract is carry-out or borrow; logic ops leave it 0.
      return {upd_flg, upd_res, r[W], r[W-1:0]};
   endfunction

   assign alu_w = alu_eval(bus.opcode, a_reg, b_reg, bus.tmp_in);

   // Register stage: A/B loads and ALU result/flags all commit on the same edge.
   always_ff @(posedge clk) begin
      if (!reset) begin
         a_reg    <= '0;
         b_reg    <= '0;
         res_p1   <= '0;
         zero_p1  <= 1'b0;
         carry_p1 <= 1'b0;
         cfb_reg  <= 1'b0;
      end else begin
         if (bus.la_alu)      a_reg <= res_p1;
         else if (bus.la_ram) a_reg <= bus.ram_in;
         else if (bus.la_b)   a_reg <= b_reg;

         if (bus.lb_alu)      b_reg <= res_p1;
         else if (bus.lpop)   b_reg <= bus.ram_in;
         else if (bus.lb_tmp) b_reg <= bus.tmp_in;
         else if (bus.lcarry) b_reg <= {{(W-1){1'b0}}, bus.carry_in};
         else if (bus.ercl) begin
            b_reg   <= {b_reg[W-2:0], bus.carry_in};
            cfb_reg <= b_reg[W-1];
         end

         if (bus.eu) begin
            if (alu_w[W+1]) res_p1 <= alu_w[W-1:0];
            if (alu_w[W+2]) begin
               carry_p1 <= alu_w[W];
               zero_p1  <= (alu_w[W-1:0] == '0);
            end
         end
      end
   end

   assign bus.a_to_tmp     = bus.ea_tmp  ? a_reg : '0;
   assign bus.a_to_ram     = bus.ea_ram  ? a_reg : '0;
   assign bus.a_to_out     = bus.ea_out  ? a_reg : '0;
   assign bus.b_to_ram     = bus.eb_push ? b_reg : '0;
   assign bus.carry_from_a = bus.ea_carry & a_reg[W-1];
   assign bus.carry_from_b = cfb_reg;
   assign bus.zero         = zero_p1;
   assign bus.carry        = carry_p1;
   assign bus.alu_result   = res_p1;

endmodule

// File: tb/tb_alu_ab_datapath.sv
// Directed plus randomized bench for alu_ab_datapath against an integer-arithmetic reference model.
module tb_alu_ab_datapath;
   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;

   // reference model state
   int ma, mb, mres;
   bit mz, mc, mcfb;

   alu_ab_datapath_if #(.W(4)) bus ();

   alu_ab_datapath #(.W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic idle();
      reset        = 1'b1;
      bus.la_ram   = 0; bus.la_b   = 0; bus.la_alu = 0;
      bus.lb_tmp   = 0; bus.lb_alu = 0; bus.lpop   = 0; bus.lcarry = 0; bus.ercl = 0;
      bus.eu       = 0;
      bus.ea_tmp   = 0; bus.ea_ram = 0; bus.ea_out = 0; bus.ea_carry = 0; bus.eb_push = 0;
   endtask

   task automatic check_all();
      logic s_tmp, s_ram, s_out, s_car, s_push;
      chk("a_to_tmp",  8'(bus.a_to_tmp),  8'(bus.ea_tmp  ? ma : 0));
      chk("a_to_ram",  8'(bus.a_to_ram),  8'(bus.ea_ram  ? ma : 0));
      chk("a_to_out",  8'(bus.a_to_out),  8'(bus.ea_out  ? ma : 0));
      chk("b_to_ram",  8'(bus.b_to_ram),  8'(bus.eb_push ? mb : 0));
      chk("carry_a",   8'(bus.carry_from_a), 8'(bus.ea_carry && ma >= 8));
      chk("carry_b",   8'(bus.carry_from_b), 8'(mcfb));
      chk("zero",      8'(bus.zero),       8'(mz));
      chk("carry",     8'(bus.carry),      8'(mc));
      chk("alu_res",   8'(bus.alu_result), 8'(mres));
      s_tmp = bus.ea_tmp; s_ram = bus.ea_ram; s_out = bus.ea_out;
      s_car = bus.ea_carry; s_push = bus.eb_push;
      bus.ea_tmp = 1; bus.ea_ram = 1; bus.ea_out = 1; bus.ea_carry = 1; bus.eb_push = 1;
      #1;
      chk("a_full",    8'(bus.a_to_out),  8'(ma));
      chk("a_ram_full",8'(bus.a_to_ram),  8'(ma));
      chk("b_full",    8'(bus.b_to_ram),  8'(mb));
      chk("ca_full",   8'(bus.carry_from_a), 8'(ma >= 8));
      bus.ea_tmp = s_tmp; bus.ea_ram = s_ram; bus.ea_out = s_out;
      bus.ea_carry = s_car; bus.eb_push = s_push;
      #1;
   endtask

   // One clock: next model state is computed from the inputs as they stand before the edge.
   task automatic tick();
      int na, nb, nres, r, a, b, t, op;
      bit nz, nc, ncfb, upd_r, upd_f, c;
      na = ma; nb = mb; nres = mres; nz = mz; nc = mc; ncfb = mcfb;
      a = ma; b = mb; t = int'(bus.tmp_in); op = int'(bus.opcode);
      if (!reset) begin
         na = 0; nb = 0; nres = 0; nz = 0; nc = 0; ncfb = 0;
      end else begin
         if (bus.la_alu)      na = mres;
         else if (bus.la_ram) na = int'(bus.ram_in);
         else if (bus.la_b)   na = mb;
         if (bus.lb_alu)      nb = mres;
         else if (bus.lpop)   nb = int'(bus.ram_in);
         else if (bus.lb_tmp) nb = t;
         else if (bus.lcarry) nb = int'(bus.carry_in);
         else if (bus.ercl) begin
            nb   = (mb * 2 + int'(bus.carry_in)) % 16;
            ncfb = (mb >= 8);
         end
         if (bus.eu) begin
            upd_r = 1; upd_f = 1; c = 0; r = 0;
            case (op)
               1:  begin r = a + b; c = (r > 15); end
               2:  begin r = a - b; c = (a < b); end
               4:  begin r = a + t; c = (r > 15); end
               5:  begin r = a - t; c = (a < t); end
               8:  r = a & b;
               9:  r = a | b;
               10: r = a ^ b;
               11: r = 15 - a;
               12: begin r = a + 1; c = (a == 15); end
               13: begin r = a - 1; c = (a == 0); end
`ifdef ALU_CMP_EN
               6:  begin r = a - b; c = (a < b); upd_r = 0; end
`endif
               default: begin upd_r = 0; upd_f = 0; end
            endcase
            r = ((r % 16) + 16) % 16;
            if (upd_r) nres = r;
            if (upd_f) begin nc = c; nz = (r == 0); end
         end
      end
      @(posedge clk);
      #1;
      ma = na; mb = nb; mres = nres; mz = nz; mc = nc; mcfb = ncfb;
      check_all();
   endtask

   task automatic peek_a(input string tag, input int exp);
      bus.ea_out = 1; #1;
      chk(tag, 8'(bus.a_to_out), 8'(exp));
      bus.ea_out = 0; #1;
   endtask

   task automatic peek_b(input string tag, input int exp);
      bus.eb_push = 1; #1;
      chk(tag, 8'(bus.b_to_ram), 8'(exp));
      bus.eb_push = 0; #1;
   endtask

   initial begin
      vectors = 0; miscompares = 0;
      ma = 0; mb = 0; mres = 0; mz = 0; mc = 0; mcfb = 0;
      idle();
      bus.opcode = 4'h0; bus.ram_in = '0; bus.tmp_in = '0; bus.carry_in = 0;
      @(negedge clk);
      reset = 0; tick(); idle();

      // reset after loading A=5, B=3
      bus.ram_in = 4'd5; bus.la_ram = 1; tick(); idle();
      bus.ram_in = 4'd3; bus.lpop = 1; tick(); idle();
      peek_a("pre_rst_a", 5); peek_b("pre_rst_b", 3);
      reset = 0; tick(); idle();
      peek_a("rst_a", 0); peek_b("rst_b", 0);
      chk("rst_res", 8'(bus.alu_result), 8'd0);

      // MOV / XCHG sequence
      bus.ram_in = 4'd1; bus.la_ram = 1; tick(); idle();
      bus.tmp_in = 4'd1; bus.lb_tmp = 1; tick(); idle();
      bus.ram_in = 4'd8; bus.la_ram = 1; tick(); idle();
      peek_a("mov_a", 8); peek_b("mov_b", 1);
      bus.ea_tmp = 1; #1; chk("ea_tmp_on", 8'(bus.a_to_tmp), 8'd8);
      bus.ea_tmp = 0; #1; chk("ea_tmp_off", 8'(bus.a_to_tmp), 8'd0);

      // SUB then ADD
      bus.opcode = 4'b0010; bus.eu = 1; tick(); idle();
      bus.la_alu = 1; tick(); idle();
      peek_a("sub_a", 7);
      chk("sub_c", 8'(bus.carry), 8'd0); chk("sub_z", 8'(bus.zero), 8'd0);
      bus.opcode = 4'b0001; bus.eu = 1; tick(); idle();
      bus.la_alu = 1; tick(); idle();
      peek_a("add_a", 8);

      // borrow and wrap
      bus.ram_in = 4'd1; bus.la_ram = 1; tick(); idle();
      bus.ram_in = 4'd8; bus.lpop = 1; tick(); idle();
      bus.opcode = 4'b0010; bus.eu = 1; tick(); idle();
      bus.la_alu = 1; tick(); idle();
      peek_a("borrow_a", 9); chk("borrow_c", 8'(bus.carry), 8'd1);
      bus.ram_in = 4'd15; bus.la_ram = 1; tick(); idle();
      bus.ram_in = 4'd1; bus.lpop = 1; tick(); idle();
      bus.opcode = 4'b0001; bus.eu = 1; tick(); idle();
      chk("wrap_res", 8'(bus.alu_result), 8'd0);
      chk("wrap_z", 8'(bus.zero), 8'd1); chk("wrap_c", 8'(bus.carry), 8'd1);

      // carry rotate and stack
      bus.ram_in = 4'd9; bus.lpop = 1; tick(); idle();
      bus.carry_in = 0; bus.ercl = 1; tick(); idle();
      peek_b("rcl_b", 2); chk("rcl_cfb", 8'(bus.carry_from_b), 8'd1);
      bus.ram_in = 4'd6; bus.lpop = 1; tick(); idle();
      peek_b("pop_b", 6);
      bus.carry_in = 1; bus.lcarry = 1; tick(); idle();
      peek_b("lcarry_b", 1);

      // A load priority, then CMP (or unused opcode 0110)
      bus.ram_in = 4'd2; bus.la_ram = 1; tick(); idle();
      bus.opcode = 4'b1100; bus.eu = 1; tick(); idle();
      bus.ram_in = 4'd9; bus.la_ram = 1; bus.la_alu = 1; tick(); idle();
      peek_a("prio_a", 3);
      bus.ram_in = 4'd3; bus.lpop = 1; tick(); idle();
      bus.opcode = 4'b0110; bus.eu = 1; tick(); idle();
      chk("cmp_res", 8'(bus.alu_result), 8'd3);
`ifdef ALU_CMP_EN
      chk("cmp_z", 8'(bus.zero), 8'd1);
`else
      chk("cmp_z", 8'(bus.zero), 8'd0);
`endif

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         reset        = ($urandom_range(0, 39) != 0);
         bus.opcode   = 4'($urandom);
         bus.ram_in   = 4'($urandom);
         bus.tmp_in   = 4'($urandom);
         bus.carry_in = 1'($urandom);
         bus.la_ram   = ($urandom_range(0, 3) == 0);
         bus.la_b     = ($urandom_range(0, 3) == 0);
         bus.la_alu   = ($urandom_range(0, 3) == 0);
         bus.lb_tmp   = ($urandom_range(0, 4) == 0);
         bus.lb_alu   = ($urandom_range(0, 4) == 0);
         bus.lpop     = ($urandom_range(0, 4) == 0);
         bus.lcarry   = ($urandom_range(0, 4) == 0);
         bus.ercl     = ($urandom_range(0, 2) == 0);
         bus.eu       = ($urandom_range(0, 1) == 0);
         bus.ea_tmp   = 1'($urandom); bus.ea_ram = 1'($urandom); bus.ea_out = 1'($urandom);
         bus.ea_carry = 1'($urandom); bus.eb_push = 1'($urandom);
         tick();
      end
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/alu_ab_datapath.md
Name: alu_ab_datapath

Overview:
- 4-bit accumulator datapath: A register, B register and a registered ALU in one block.
- Sits between the RAM, TMP, OUT and flag blocks of the 4-bit CPU.
- Driven by control-sequencer strobes and the IR opcode nibble.
- Supports MOV A,mem, XCHG (via TMP), ADD/SUB/logic, push/pop of B, and carry transfers.

Parameters:
- W, 4, datapath width (all data ports and registers).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- opcode  in  4  IR opcode nibble selecting the ALU operation.
- ram_in  in  W  RAM read data; used for A load and B pop.
- tmp_in  in  W  TMP register data; used for B load and as ALU operand.
- carry_in  in  1  carry flag value from the flag register.
- la_ram  in  1  load A from ram_in.
- la_b  in  1  load A from B.
- la_alu  in  1  load A from the ALU result.
- lb_tmp  in  1  load B from tmp_in.
- lb_alu  in  1  load B from the ALU result.
- lpop  in  1  load B from ram_in (pop).
- lcarry  in  1  B <= {0,0,0,carry_in}.
- ercl  in  1  rotate B left through carry.
- eu  in  1  execute ALU: register result and flags.
- ea_tmp, ea_ram, ea_out, ea_carry, eb_push  in  1 each  output enables.
- a_to_tmp, a_to_ram, a_to_out  out  W  A value when the matching enable is 1, else 0.
- b_to_ram  out  W  B value when eb_push=1, else 0.
- carry_from_a  out  1  A[3] when ea_carry=1, else 0.
- carry_from_b  out  1  bit rotated out of B by ercl (registered).
- zero  out  1  registered zero flag.
- carry  out  1  registered carry/borrow flag.
- alu_result  out  W  registered ALU result (debug/visibility).

Behaviour:
- Reset (reset=0 at a rising edge): A, B, alu_result, zero, carry and carry_from_b all go to 0. Reset overrides every load.
- A load priority: la_alu > la_ram > la_b. A holds when none is asserted. la_b copies B as it was before the edge.
- B load priority: lb_alu > lpop > lb_tmp > lcarry > ercl. B holds when none is asserted.
- ercl: B <= {B[2:0], carry_in}; carry_from_b <= old B[3]. carry_from_b changes only on ercl or reset.
- XCHG is done externally in three cycles (A->TMP, B->A, TMP->B). Same-edge A/B loads use pre-edge values.
- ALU, on eu=1: alu_result, zero and carry are updated together at the edge. Operands are A/B/tmp_in as they were before that edge.
  - 0001: A+B; carry = bit 4 of the sum.
  - 0010: A-B mod 16; carry = borrow (A<B).
  - 0100: A+tmp_in.
  - 0101: A-tmp_in.
  - 1000: A&B.
  - 1001: A|B.
  - 1010: A^B.
  - 1011: ~A.
  - 1100: A+1 (carry on wrap from 15).
  - 1101: A-1 (borrow on 0).
  - Logic ops clear carry.
  - zero = (result==0).
  - Any other opcode: result and flags hold.
- Latency: eu in cycle N; la_alu/lb_alu in cycle N+1 loads the registered result. Asserting eu and la_alu in the same cycle loads the old result.
- Output enables are combinational gates on current register values; a disabled output drives 0.

Optional Feature:
- Macro ALU_CMP_EN.
- Defined: opcode 0110 = CMP. Computes A-B, updates zero/carry exactly as SUB, leaves alu_result unchanged.
- Undefined: 0110 is an unused opcode (no state change).

Test Plan:
- Reset: load A=5, B=3, then drive reset=0 for one edge -> A, B, zero, carry, alu_result, carry_from_b all 0.
- MOV/XCHG: la_ram with ram_in=1, then lb_tmp with tmp_in=1, then la_ram with ram_in=8 -> A=8, B=1; ea_tmp=1 shows 8 on a_to_tmp, 0 when ea_tmp=0.
- SUB then ADD: A=8, B=1, opcode 0010, eu, then la_alu -> A=7, carry=0, zero=0; opcode 0001, eu, la_alu -> A=8.
- Wrap/borrow: A=1, B=8, opcode 0010, eu, la_alu -> A=9, carry=1; A=15, B=1, opcode 0001 -> result 0, zero=1, carry=1.
- Carry/stack: B=1001, carry_in=0, ercl -> B=0010, carry_from_b=1; eb_push -> b_to_ram=2; lpop with ram_in=6 -> B=6; lcarry with carry_in=1 -> B=1.
- Priority: la_alu and la_ram asserted together -> A takes the ALU result; with ALU_CMP_EN, CMP A=3, B=3 -> zero=1 and alu_result unchanged.
